// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path.
// Holds frame geometry, the FT245 byte-lane layout of a pixel, the
// write-side FSM state type and the pixel packing helper.
package fb_pkg;

  localparam int FRAME_PIXELS  = 16384;
  localparam int FB_ADDR_WIDTH = 14;
  localparam int FB_DATA_WIDTH = 20;

  // b2 carries the start-of-frame flag in its MSB.
  localparam int SOF_BIT = 7;

  // Byte lanes of one pixel as they arrive on the FIFO.
  localparam logic [1:0] LANE_B0 = 2'd0;  // pix[7:0]
  localparam logic [1:0] LANE_B1 = 2'd1;  // pix[15:8]
  localparam logic [1:0] LANE_B2 = 2'd2;  // {SOF, 3'bx, pix[19:16]}

  typedef enum logic [1:0] {IDLE, OE, READ, FULL} fb_wr_state_t;

  // Assemble a pixel from its two low bytes and the low nibble of b2.
  function automatic logic [FB_DATA_WIDTH-1:0] fb_pack_pixel(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [3:0] hi
  );
    return {hi, b1, b0};
  endfunction

endpackage

// File: rtl/fb_write_ctrl_if.sv
// Bus bundle between the write controller and its surroundings.
//   FT245 read side : ftdi_data, ftdi_rxf_n (in), ftdi_oe_n, ftdi_rd_n (out)
//   Framebuffer port: wdata, waddr, we (out)
//   Swap handshake  : full_ftdi (out), swapped_ftdi (in)
// master = the controller, slave = FIFO/framebuffer/swap logic.
interface fb_write_ctrl_if;

  logic [7:0]                       ftdi_data;
  logic                             ftdi_rxf_n;
  logic                             ftdi_oe_n;
  logic                             ftdi_rd_n;
  logic [fb_pkg::FB_DATA_WIDTH-1:0] wdata;
  logic [fb_pkg::FB_ADDR_WIDTH-1:0] waddr;
  logic                             we;
  logic                             full_ftdi;
  logic                             swapped_ftdi;

  modport master (
    input  ftdi_data, ftdi_rxf_n, swapped_ftdi,
    output ftdi_oe_n, ftdi_rd_n, wdata, waddr, we, full_ftdi
  );

  modport slave (
    output ftdi_data, ftdi_rxf_n, swapped_ftdi,
    input  ftdi_oe_n, ftdi_rd_n, wdata, waddr, we, full_ftdi
  );

endinterface

// File: rtl/ftdi_sync_rx.sv
// FT245 synchronous-FIFO read handshake.
// Ports:
//   clk_60, rst_n : clock, synchronous active-low reset
//   rxf_n         : FIFO has data (active low)
//   stall         : the byte accepted this cycle completes the frame;
//                   stop reading and park in FULL
//   resume        : leave FULL (buffer swap seen)
//   oe_n, rd_n    : FT245 output enable / read strobe
//   byte_vld      : ftdi_data holds an accepted byte this cycle
module ftdi_sync_rx
  import fb_pkg::*;
(
  input  logic clk_60,
  input  logic rst_n,
  input  logic rxf_n,
  input  logic stall,
  input  logic resume,
  output logic oe_n,
  output logic rd_n,
  output logic byte_vld
);

  fb_wr_state_t state_q, state_d;

  always_ff @(posedge clk_60) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Kept out of the FSM block: stall is derived from byte_vld in the
  // parent, so folding it in would look like a combinational loop.
  assign byte_vld = (state_q == READ) && !rxf_n;

  always_comb begin
    state_d = state_q;
    oe_n    = 1'b1;
    rd_n    = 1'b1;
    unique case (state_q)
      IDLE: if (!rxf_n) state_d = OE;
      // One bus-turnaround cycle with the FTDI driving before strobing.
      OE: begin
        oe_n    = 1'b0;
        state_d = rxf_n ? IDLE : READ;
      end
      READ: begin
        oe_n = 1'b0;
        rd_n = 1'b0;
        if (rxf_n)      state_d = IDLE;
        else if (stall) state_d = FULL;
      end
      FULL: if (resume) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/fb_write_ctrl.sv
// Write-side controller of the double-buffered framebuffer (clk_60 domain).
// Drains the FT245 byte stream, packs three bytes per 20-bit pixel and
// writes it to the framebuffer. After the last pixel of a frame it raises
// full_ftdi and stops reading until swapped_ftdi arrives.
// Ports:
//   clk_60, rst_n : FTDI clock, synchronous active-low reset
//   bus (master)  : FT245 read bus, framebuffer write port, full/swap
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
  parameter int ADDR_WIDTH   = fb_pkg::FB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = fb_pkg::FB_DATA_WIDTH
) (
  input  logic                   clk_60,
  input  logic                   rst_n,
  fb_write_ctrl_if.master        bus
);

  logic [1:0]            idx_q, idx_d;
  logic [7:0]            b0_q, b0_d, b1_q, b1_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d, full_q, full_d;

  logic                  byte_vld, pix_done, sof, frame_end, resume;
  logic [ADDR_WIDTH-1:0] tgt_addr;

  // Only the trailing byte of a pixel carries SOF; tgt_addr is meaningful
  // only when pix_done is set.
  assign pix_done  = byte_vld && (idx_q == LANE_B2);
  assign sof       = bus.ftdi_data[SOF_BIT];
  assign tgt_addr  = sof ? '0 : addr_q;
  assign frame_end = pix_done && (tgt_addr == ADDR_WIDTH'(FRAME_PIXELS - 1));
  // A swap pulse means nothing unless a frame is waiting on it.
  assign resume    = full_q && bus.swapped_ftdi;

  ftdi_sync_rx u_rx (
    .clk_60   (clk_60),
    .rst_n    (rst_n),
    .rxf_n    (bus.ftdi_rxf_n),
    .stall    (frame_end),
    .resume   (resume),
    .oe_n     (bus.ftdi_oe_n),
    .rd_n     (bus.ftdi_rd_n),
    .byte_vld (byte_vld)
  );

  always_comb begin
    idx_d   = idx_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    full_d  = full_q;
    // Byte index and partial pixel persist across FIFO-empty gaps.
    if (byte_vld) begin
      case (idx_q)
        LANE_B0: begin
          b0_d  = bus.ftdi_data;
          idx_d = LANE_B1;
        end
        LANE_B1: begin
          b1_d  = bus.ftdi_data;
          idx_d = LANE_B2;
        end
        default: begin
          we_d    = 1'b1;
          wdata_d = DATA_WIDTH'(fb_pack_pixel(b0_q, b1_q, bus.ftdi_data[3:0]));
          waddr_d = tgt_addr;
          // Wraps only on the last pixel; FULL holds it until the swap
          // clears it anyway.
          addr_d  = tgt_addr + 1'b1;
          idx_d   = LANE_B0;
          if (frame_end) full_d = 1'b1;
        end
      endcase
    end
    if (resume) begin
      full_d = 1'b0;
      addr_d = '0;
      idx_d  = LANE_B0;
    end
  end

  always_ff @(posedge clk_60) begin
    if (!rst_n) begin
      idx_q   <= LANE_B0;
      b0_q    <= '0;
      b1_q    <= '0;
      addr_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      full_q  <= full_d;
    end
  end

  assign bus.wdata     = wdata_q;
  assign bus.waddr     = waddr_q;
  assign bus.we        = we_q;
  assign bus.full_ftdi = full_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Bench for fb_write_ctrl: a behavioural FT245 FIFO feeds bytes, a
// queue-based model turns consumed bytes into expected framebuffer writes.
module tb_fb_write_ctrl;
  import fb_pkg::*;

  localparam int FP = 16384;

  logic clk_60 = 1'b0;
  logic rst_n  = 1'b0;
  always #8 clk_60 = ~clk_60;

  fb_write_ctrl_if bus ();

  fb_write_ctrl #(.FRAME_PIXELS(FP), .ADDR_WIDTH(14), .DATA_WIDTH(20)) dut (
    .clk_60 (clk_60),
    .rst_n  (rst_n),
    .bus    (bus.master)
  );

  typedef struct packed {
    logic [13:0] a;
    logic [19:0] d;
    logic        f;
  } wr_t;

  logic [7:0] fifo[$];
  logic [7:0] pend[$];
  wr_t        exp_q[$];
  wr_t        obs_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int gap_pct = 0;
  bit swap_req = 1'b0;
  bit swap_at_eof = 1'b0;
  int model_addr = 0;
  bit model_full = 1'b0;
  int rd_in_full = 0;
  int order_err = 0;
  logic prev_oe = 1'b1;
  int ea;

  // FT245 FIFO + reference model, evaluated on the falling edge.
  initial begin
    bus.ftdi_rxf_n   = 1'b1;
    bus.ftdi_data    = 8'h00;
    bus.swapped_ftdi = 1'b0;
    forever begin
      @(negedge clk_60);
      if (bus.we === 1'b1) obs_q.push_back('{bus.waddr, bus.wdata, bus.full_ftdi});
      if (bus.full_ftdi === 1'b1 && !(bus.ftdi_rd_n === 1'b1 && bus.ftdi_oe_n === 1'b1))
        rd_in_full++;
      if (bus.ftdi_rd_n === 1'b0 && (bus.ftdi_oe_n !== 1'b0 || prev_oe !== 1'b0))
        order_err++;
      prev_oe = bus.ftdi_oe_n;
      // Swap is honoured only when a complete frame is waiting.
      bus.swapped_ftdi = swap_req;
      if (swap_req && model_full) begin
        model_full = 1'b0;
        model_addr = 0;
        pend.delete();
      end
      swap_req = 1'b0;
      bus.ftdi_rxf_n = !rst_n || (fifo.size() == 0) || ($urandom_range(0, 99) < gap_pct);
      bus.ftdi_data  = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
      // The FIFO pops on every edge that sees rd_n and rxf_n both low.
      if (!bus.ftdi_rxf_n && bus.ftdi_rd_n === 1'b0) begin
        pend.push_back(fifo.pop_front());
        if (pend.size() == 3) begin
          ea = pend[2][7] ? 0 : model_addr;
          exp_q.push_back('{ea[13:0], {pend[2][3:0], pend[1], pend[0]}, (ea == FP - 1)});
          model_addr = ea + 1;
          if (ea == FP - 1) begin
            model_full = 1'b1;
            if (swap_at_eof) begin
              bus.swapped_ftdi = 1'b1;
              swap_at_eof = 1'b0;
            end
          end
          pend.delete();
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_60);
      #2;
    end
  endtask

  task automatic push_pix(input logic [19:0] p, input bit sof);
    fifo.push_back(p[7:0]);
    fifo.push_back(p[15:8]);
    fifo.push_back({sof, 3'($urandom), p[19:16]});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    n_tests++; if (bus.ftdi_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n got %b want 1", bus.ftdi_oe_n); end
    n_tests++; if (bus.ftdi_rd_n !== 1'b1) begin n_fail++; $display("FAIL reset_rd_n got %b want 1", bus.ftdi_rd_n); end
    n_tests++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", bus.we); end
    n_tests++; if (bus.wdata !== 20'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", bus.wdata); end
    n_tests++; if (bus.waddr !== 14'h0) begin n_fail++; $display("FAIL reset_waddr got %h want 0", bus.waddr); end
    n_tests++; if (bus.full_ftdi !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full_ftdi); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_pixel;
    int c = 0;
    fifo.push_back(8'h34); fifo.push_back(8'h12); fifo.push_back(8'h05);
    while (bus.ftdi_oe_n !== 1'b0 && c < 50) begin tick(); c++; end
    n_tests++;
    if (bus.ftdi_oe_n !== 1'b0 || bus.ftdi_rd_n !== 1'b1) begin
      n_fail++; $display("FAIL oe_before_rd got oe_n=%b rd_n=%b want 0/1", bus.ftdi_oe_n, bus.ftdi_rd_n);
    end
    tick();
    n_tests++;
    if (bus.ftdi_rd_n !== 1'b0) begin n_fail++; $display("FAIL rd_after_oe got rd_n=%b want 0", bus.ftdi_rd_n); end
    c = 0;
    while (obs_q.size() < 1 && c < 50) begin tick(); c++; end
    tick(3);
    n_tests++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL first_we_count got %0d want 1", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== wr_t'({14'd0, 20'h51234, 1'b0})) begin
        n_fail++; $display("FAIL first_pixel got a=%0d d=%h f=%b want a=0 d=51234 f=0", obs_q[0].a, obs_q[0].d, obs_q[0].f);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_gap;
    logic [7:0] b0 = 8'($urandom);
    logic [7:0] b1 = 8'($urandom);
    int c = 0;
    fifo.push_back(b0); fifo.push_back(b1);
    while (fifo.size() != 0 && c < 50) begin tick(); c++; end
    tick(10);
    n_tests++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL gap_early_we got %0d writes want 0", obs_q.size()); end
    fifo.push_back(8'h0A);
    c = 0;
    while (obs_q.size() < 1 && c < 50) begin tick(); c++; end
    tick(3);
    n_tests++;
    if (obs_q.size() != 1 || fifo.size() != 0) begin
      n_fail++; $display("FAIL gap_count got writes=%0d left=%0d want 1/0", obs_q.size(), fifo.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== wr_t'({14'd1, {4'hA, b1, b0}, 1'b0})) begin
        n_fail++; $display("FAIL gap_pixel got a=%0d d=%h want a=1 d=%h", obs_q[0].a, obs_q[0].d, {4'hA, b1, b0});
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_sof_resync;
    int c = 0;
    gap_pct = 20;
    for (int i = 0; i < 100; i++) push_pix(20'($urandom), 1'b0);
    push_pix(20'($urandom), 1'b1);
    push_pix(20'($urandom), 1'b0);
    while (obs_q.size() < 102 && c < 5000) begin tick(); c++; end
    tick(3);
    gap_pct = 0;
    n_tests++;
    if (obs_q.size() != 102 || exp_q.size() != 102) begin
      n_fail++; $display("FAIL sof_count got %0d want %0d (model) / 102", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL sof_pix%0d got a=%0d d=%h f=%b want a=%0d d=%h f=%b", i,
          obs_q[i].a, obs_q[i].d, obs_q[i].f, exp_q[i].a, exp_q[i].d, exp_q[i].f);
      end
    end
    if (obs_q.size() == 102) begin
      n_tests++;
      if (obs_q[100].a !== 14'd0 || obs_q[101].a !== 14'd1) begin
        n_fail++; $display("FAIL sof_addr got %0d,%0d want 0,1", obs_q[100].a, obs_q[101].a);
      end
    end
    n_tests++;
    if (bus.full_ftdi !== 1'b0) begin n_fail++; $display("FAIL sof_full got %b want 0", bus.full_ftdi); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_swap_ignored;
    int c = 0;
    swap_req = 1'b1;
    tick(5);
    n_tests++;
    if (bus.full_ftdi !== 1'b0 || bus.ftdi_oe_n !== 1'b1) begin
      n_fail++; $display("FAIL swap_idle got full=%b oe_n=%b want 0/1", bus.full_ftdi, bus.ftdi_oe_n);
    end
    for (int i = 0; i < 30; i++) push_pix(20'($urandom), 1'b0);
    while (bus.ftdi_rd_n !== 1'b0 && c < 50) begin tick(); c++; end
    swap_req = 1'b1;
    c = 0;
    while (obs_q.size() < 30 && c < 500) begin tick(); c++; end
    tick(3);
    n_tests++;
    if (obs_q.size() != 30 || exp_q.size() != 30) begin
      n_fail++; $display("FAIL swap_count got %0d want %0d (model) / 30", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL swap_pix%0d got a=%0d d=%h want a=%0d d=%h", i, obs_q[i].a, obs_q[i].d, exp_q[i].a, exp_q[i].d);
      end
    end
    n_tests++;
    if (bus.full_ftdi !== 1'b0) begin n_fail++; $display("FAIL swap_read_full got %b want 0", bus.full_ftdi); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_pixel;
    logic [19:0] p = 20'($urandom);
    int c = 0;
    fifo.push_back(8'($urandom)); fifo.push_back(8'($urandom));
    while (fifo.size() != 0 && c < 50) begin tick(); c++; end
    tick(3);
    rst_n = 1'b0;
    pend.delete();
    model_addr = 0;
    tick(2);
    n_tests++;
    if (bus.ftdi_oe_n !== 1'b1 || bus.ftdi_rd_n !== 1'b1 || bus.we !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctl got oe_n=%b rd_n=%b we=%b want 1/1/0", bus.ftdi_oe_n, bus.ftdi_rd_n, bus.we);
    end
    n_tests++;
    if (bus.wdata !== 20'h0 || bus.waddr !== 14'h0 || bus.full_ftdi !== 1'b0) begin
      n_fail++; $display("FAIL midrst_data got wdata=%h waddr=%0d full=%b want 0/0/0", bus.wdata, bus.waddr, bus.full_ftdi);
    end
    rst_n = 1'b1;
    tick();
    push_pix(p, 1'b0);
    c = 0;
    while (obs_q.size() < 1 && c < 50) begin tick(); c++; end
    tick(3);
    n_tests++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL midrst_count got %0d want 1", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== wr_t'({14'd0, p, 1'b0})) begin
        n_fail++; $display("FAIL midrst_pixel got a=%0d d=%h want a=0 d=%h", obs_q[0].a, obs_q[0].d, p);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_frame;
    logic [19:0] p_after = 20'($urandom);
    int c = 0;
    int viol = 0;
    gap_pct = 2;
    swap_at_eof = 1'b1;
    for (int i = 0; i < FP; i++) push_pix(20'($urandom), (i == 0));
    push_pix(p_after, 1'b0);
    while (bus.full_ftdi !== 1'b1 && c < 70000) begin tick(); c++; end
    gap_pct = 0;
    n_tests++;
    if (bus.full_ftdi !== 1'b1 || bus.we !== 1'b1 || bus.waddr !== 14'(FP - 1)) begin
      n_fail++; $display("FAIL frame_end got full=%b we=%b waddr=%0d want 1/1/%0d", bus.full_ftdi, bus.we, bus.waddr, FP - 1);
    end
    tick();
    n_tests++;
    if (obs_q.size() != FP || exp_q.size() != FP) begin
      n_fail++; $display("FAIL frame_count got %0d want %0d (model) / %0d", obs_q.size(), exp_q.size(), FP);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].a !== 14'(i)) begin
        n_fail++; $display("FAIL frame_pix%0d got a=%0d d=%h f=%b want a=%0d d=%h f=%b", i,
          obs_q[i].a, obs_q[i].d, obs_q[i].f, exp_q[i].a, exp_q[i].d, exp_q[i].f);
      end
    end
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.ftdi_rxf_n !== 1'b0 || bus.ftdi_rd_n !== 1'b1 || bus.ftdi_oe_n !== 1'b1 || bus.full_ftdi !== 1'b1) viol++;
    end
    n_tests++;
    if (viol != 0) begin n_fail++; $display("FAIL full_hold got %0d bad cycles want 0", viol); end
    n_tests++;
    if (fifo.size() != 3) begin n_fail++; $display("FAIL full_no_read got %0d bytes left want 3", fifo.size()); end
    swap_req = 1'b1;
    tick();
    n_tests++;
    if (bus.swapped_ftdi !== 1'b1 || bus.full_ftdi !== 1'b0) begin
      n_fail++; $display("FAIL swap_release got swapped=%b full=%b want 1/0", bus.swapped_ftdi, bus.full_ftdi);
    end
    c = 0;
    while (obs_q.size() < 1 && c < 50) begin tick(); c++; end
    tick(3);
    n_tests++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL after_swap_count got %0d want 1", obs_q.size());
    end else begin
      n_tests++;
      if (obs_q[0] !== wr_t'({14'd0, p_after, 1'b0})) begin
        n_fail++; $display("FAIL after_swap_pixel got a=%0d d=%h want a=0 d=%h", obs_q[0].a, obs_q[0].d, p_after);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_protocol;
    n_tests++;
    if (rd_in_full != 0) begin n_fail++; $display("FAIL read_in_full got %0d want 0", rd_in_full); end
    n_tests++;
    if (order_err != 0) begin n_fail++; $display("FAIL oe_rd_order got %0d want 0", order_err); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_gap();
    test_sof_resync();
    test_swap_ignored();
    test_reset_mid_pixel();
    test_full_frame();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
